// File: rtl/inst_fetch.sv
// Instruction-fetch unit: assembles a 32-bit little-endian instruction from four
// byte reads, hands it to IF/ID, and locks the PC while a fetch is outstanding.
module inst_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter bit BOOT_FETCH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  pc_changed_i,
  input  logic                  pc_branch_i,
  input  logic                  id_stall_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [7:0]            mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  stall_o,
  output logic [31:0]           inst_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  output logic                  inst_valid_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] iaddr_q, iaddr_d;
  logic [31:0]           inst_q, inst_d;
  logic                  launch;

  // Byte address within the current word; wraps modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] byte_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [2:0]            off);
    return base + ADDR_WIDTH'(off);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    req_d   = req_q;
    base_d  = base_q;
    addr_d  = addr_q;
    iaddr_d = iaddr_q;
    inst_d  = inst_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_branch_i) begin
          pend_d = 1'b1;
        end else if (pc_changed_i || pend_q) begin
          launch  = 1'b1;
          base_d  = pc_i;
          cnt_d   = 2'd0;
          addr_d  = pc_i;
          req_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (pc_branch_i) begin
          // A byte still in flight must be drained before the bus is free again.
          pend_d = 1'b1;
          if (mem_ready_i) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_ready_i) begin
          inst_d[{cnt_q, 3'b000} +: 8] = mem_rdata_i;
          cnt_d  = cnt_q + 2'd1;
          addr_d = byte_addr(base_q, {1'b0, cnt_q} + 3'd1);
          if (cnt_q == 2'd3) begin
            req_d   = 1'b0;
            iaddr_d = base_q;
            state_d = VALID;
          end
        end
      end
      VALID: begin
        if (pc_branch_i) begin
          pend_d  = 1'b1;
          state_d = IDLE;
        end else if (!id_stall_i) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (mem_ready_i) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      pend_q  <= BOOT_FETCH;
      req_q   <= 1'b0;
      base_q  <= '0;
      addr_q  <= '0;
      iaddr_q <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      iaddr_q <= iaddr_d;
      inst_q  <= inst_d;
    end
  end

  // The PC may only move in the cycle the instruction actually leaves VALID.
  assign stall_o = rst && (launch || (state_q == FETCH) || (state_q == DRAIN) ||
                           ((state_q == VALID) && id_stall_i) ||
                           ((state_q == IDLE) && pend_q));

  assign inst_valid_o = (state_q == VALID) && !pc_branch_i;
  assign mem_req_o    = req_q;
  assign mem_addr_o   = addr_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = iaddr_q;

endmodule
